// File: rtl/matrix_sel_pkg.sv
// Shared parameters and layout index helpers for the 64x64 -> 16x16 re-tiler.
// Index helpers return widths sized to the bus they address.
package matrix_sel_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned N       = 64;
  localparam int unsigned T       = 16;
  localparam int unsigned NT      = N / T;
  localparam int unsigned TILE_W  = T * T * DW;
  localparam int unsigned STRIP_W = N * T * DW;
  localparam int unsigned MAT_W   = N * N * DW;

  typedef logic [DW-1:0]                elem_t;
  typedef logic [$clog2(MAT_W)-1:0]     mat_idx_t;
  typedef logic [$clog2(STRIP_W)-1:0]   strip_idx_t;

  // Bit offset of element (r,c) in the flattened matrix.
  function automatic mat_idx_t mat_off(input int unsigned r, input int unsigned c);
    return mat_idx_t'((r * N + c) * DW);
  endfunction

  // Bit offset of element (r,j) of strip k within the concatenated strip bus.
  function automatic mat_idx_t strips_off(input int unsigned k, input int unsigned r,
                                          input int unsigned j);
    return mat_idx_t'(k * STRIP_W + (r * T + j) * DW);
  endfunction

  // Bit offset of element (r,j) within a single strip.
  function automatic strip_idx_t strip_off(input int unsigned r, input int unsigned j);
    return strip_idx_t'((r * T + j) * DW);
  endfunction

  // Bit offset of element (i,j) of tile m within one strip's group of tiles.
  function automatic strip_idx_t tiles_off(input int unsigned m, input int unsigned i,
                                           input int unsigned j);
    return strip_idx_t'(m * TILE_W + (i * T + j) * DW);
  endfunction

endpackage

// File: rtl/matrix_sel_64_tile_if.sv
// Capture/result bus of the re-tiler: strobe and matrix in, tiles and done out.
interface matrix_sel_64_tile_if;
  import matrix_sel_pkg::*;

  logic             en;
  logic [MAT_W-1:0] matrix;
  logic [MAT_W-1:0] tiles;
  logic             done;

  modport master (output en, output matrix, input tiles, input done);
  modport slave  (input en, input matrix, output tiles, output done);
endinterface

// File: rtl/matrix_sel_strip_split.sv
// Stage 2 row splitter: cuts one 64x16 strip into NT 16x16 tiles, one register
// stage; done is sticky once a copy has occurred.
module matrix_sel_strip_split
  import matrix_sel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [STRIP_W-1:0]   strip,
  output logic [NT*TILE_W-1:0] tiles,
  output logic                 done
);

  logic [NT*TILE_W-1:0] tiles_nxt;

  // Rewire strip rows m*T..m*T+T-1 into tile m.
  always_comb begin
    tiles_nxt = '0;
    for (int unsigned m = 0; m < NT; m++)
      for (int unsigned i = 0; i < T; i++)
        for (int unsigned j = 0; j < T; j++)
          tiles_nxt[tiles_off(m, i, j) +: DW] = strip[strip_off(m * T + i, j) +: DW];
  end

  // Tile register and sticky done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tiles <= '0;
      done  <= 1'b0;
    end else if (en) begin
      tiles <= tiles_nxt;
      done  <= 1'b1;
    end
  end

endmodule

// File: rtl/matrix_sel_64_tile.sv
// Two-stage re-tiler: 64x64 matrix -> 4 column strips -> 16 tiles of 16x16.
// Optional macro MATRIX_SEL_STRIP_OUT_EN exposes the Stage 1 strips/col_done.
module matrix_sel_64_tile
  import matrix_sel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  matrix_sel_64_tile_if.slave  bus
`ifdef MATRIX_SEL_STRIP_OUT_EN
  ,
  output logic [MAT_W-1:0]     strips,
  output logic                 col_done
`endif
);

  logic [MAT_W-1:0] strip_nxt;
  logic [MAT_W-1:0] strip_q;
  logic             col_done_q;
  logic [MAT_W-1:0] tiles_w;
  logic [NT-1:0]    split_done;

  // Rewire matrix columns 16k..16k+15 into strip k.
  always_comb begin
    strip_nxt = '0;
    for (int unsigned k = 0; k < NT; k++)
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned j = 0; j < T; j++)
          strip_nxt[strips_off(k, r, j) +: DW] = bus.matrix[mat_off(r, k * T + j) +: DW];
  end

  // Stage 1 strip register and sticky col_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strip_q    <= '0;
      col_done_q <= 1'b0;
    end else if (bus.en) begin
      strip_q    <= strip_nxt;
      col_done_q <= 1'b1;
    end
  end

  // Stage 2 keeps re-copying the strips every cycle once any strip is valid,
  // which is what makes a new capture appear on the tiles two edges later.
  for (genvar k = 0; k < NT; k++) begin : g_split
    matrix_sel_strip_split u_split (
      .clk   (clk),
      .rst   (rst),
      .en    (col_done_q),
      .strip (strip_q[k*STRIP_W +: STRIP_W]),
      .tiles (tiles_w[k*NT*TILE_W +: NT*TILE_W]),
      .done  (split_done[k])
    );
  end

  assign bus.tiles = tiles_w;
  assign bus.done  = &split_done;

`ifdef MATRIX_SEL_STRIP_OUT_EN
  assign strips   = strip_q;
  assign col_done = col_done_q;
`endif

endmodule

// File: tb/tb_matrix_sel_64_tile.sv
// Directed self-checking bench for matrix_sel_64_tile.
module tb_matrix_sel_64_tile;
  import matrix_sel_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_sel_64_tile_if bus ();

`ifdef MATRIX_SEL_STRIP_OUT_EN
  logic [MAT_W-1:0] strips;
  logic             col_done;
`endif

  matrix_sel_64_tile dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef MATRIX_SEL_STRIP_OUT_EN
    ,
    .strips   (strips),
    .col_done (col_done)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tile t element (i,j): 256 elements of 16 bits per tile.
  function automatic logic [15:0] tile_el(input int unsigned t, input int unsigned i,
                                          input int unsigned j);
    logic [15:0] idx;
    idx = 16'((t * 256 + i * 16 + j) * 16);
    return bus.tiles[idx +: 16];
  endfunction

  // Expected ramp value: tile t=k*4+m holds matrix(m*16+i, k*16+j), matrix(r,c)=r*64+c.
  function automatic logic [15:0] ramp_exp(input int unsigned t, input int unsigned i,
                                           input int unsigned j);
    int unsigned k, m;
    k = t / 4;
    m = t % 4;
    return 16'((m * 16 + i) * 64 + k * 16 + j);
  endfunction

  function automatic int bad_ramp();
    int n = 0;
    for (int unsigned t = 0; t < 16; t++)
      for (int unsigned i = 0; i < 16; i++)
        for (int unsigned j = 0; j < 16; j++)
          if (tile_el(t, i, j) !== ramp_exp(t, i, j)) n++;
    return n;
  endfunction

  function automatic int bad_fill(input logic [15:0] v);
    int n = 0;
    for (int unsigned t = 0; t < 16; t++)
      for (int unsigned i = 0; i < 16; i++)
        for (int unsigned j = 0; j < 16; j++)
          if (tile_el(t, i, j) !== v) n++;
    return n;
  endfunction

  function automatic int bad_signed();
    int n = 0;
    logic [15:0] e;
    for (int unsigned t = 0; t < 16; t++)
      for (int unsigned i = 0; i < 16; i++)
        for (int unsigned j = 0; j < 16; j++) begin
          if (t == 0 && i == 0 && j == 0)        e = 16'h8000;
          else if (t == 15 && i == 15 && j == 15) e = 16'hFFFF;
          else                                    e = 16'h5A5A;
          if (tile_el(t, i, j) !== e) n++;
        end
    return n;
  endfunction

  task automatic set_fill(input logic [15:0] v);
    logic [15:0] idx;
    for (int unsigned r = 0; r < 64; r++)
      for (int unsigned c = 0; c < 64; c++) begin
        idx = 16'((r * 64 + c) * 16);
        bus.matrix[idx +: 16] = v;
      end
  endtask

  task automatic set_ramp();
    logic [15:0] idx;
    for (int unsigned r = 0; r < 64; r++)
      for (int unsigned c = 0; c < 64; c++) begin
        idx = 16'((r * 64 + c) * 16);
        bus.matrix[idx +: 16] = 16'(r * 64 + c);
      end
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.matrix = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_tiles_bad", 32'(bad_fill(16'h0000)), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single capture of the ramp matrix.
    set_ramp();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    check("cap_done_early", 32'(bus.done), 32'd0);
    check("cap_tiles_early", 32'(bad_fill(16'h0000)), 32'd0);
`ifdef MATRIX_SEL_STRIP_OUT_EN
    check("cap_col_done", 32'(col_done), 32'd1);
    check("cap_strip1_r0j0", 32'(strips[16384 +: 16]), 32'd16);
`endif
    tick();
    check("cap_done", 32'(bus.done), 32'd1);
    check("cap_t0_00", 32'(tile_el(0, 0, 0)), 32'd0);
    check("cap_t5_00", 32'(tile_el(5, 0, 0)), 32'd1040);
    check("cap_t15_ff", 32'(tile_el(15, 15, 15)), 32'd4095);
    check("cap_t6_27", 32'(tile_el(6, 2, 7)), 32'd2199); // k=1,m=2: (34,23)
    check("cap_ramp_bad", 32'(bad_ramp()), 32'd0);

    // Hold: matrix changes, en stays low.
    set_fill(16'h1234);
    repeat (10) tick();
    check("hold_ramp_bad", 32'(bad_ramp()), 32'd0);
    check("hold_done", 32'(bus.done), 32'd1);

    // Signed / bit integrity.
    set_fill(16'h5A5A);
    bus.matrix[15:0]          = 16'h8000;
    bus.matrix[65535:65520]   = 16'hFFFF;
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    check("sgn_latency", 32'(tile_el(15, 15, 15)), 32'd4095);
    tick();
    check("sgn_t0_00", 32'(tile_el(0, 0, 0)), 32'h8000);
    check("sgn_t15_ff", 32'(tile_el(15, 15, 15)), 32'hFFFF);
    check("sgn_all_bad", 32'(bad_signed()), 32'd0);

    // Back-to-back A, B, C.
    set_fill(16'd1);
    bus.en = 1'b1;
    tick();
    set_fill(16'd2);
    tick();
    check("b2b_A_t7", 32'(tile_el(7, 3, 9)), 32'd1);
    check("b2b_A_bad", 32'(bad_fill(16'd1)), 32'd0);
    set_fill(16'd3);
    tick();
    bus.en = 1'b0;
    check("b2b_B_bad", 32'(bad_fill(16'd2)), 32'd0);
    tick();
    check("b2b_C_bad", 32'(bad_fill(16'd3)), 32'd0);
    tick();
    check("b2b_C_hold", 32'(bad_fill(16'd3)), 32'd0);

    // Asynchronous reset mid-cycle with data present.
    #2;
    rst = 1'b1;
    #1;
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_tiles_bad", 32'(bad_fill(16'h0000)), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset between capture and tile load: capture is discarded.
    set_fill(16'd1);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (4) tick();
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_tiles_bad", 32'(bad_fill(16'h0000)), 32'd0);

    // Restart after reset keeps the 2-edge latency.
    @(negedge clk);
    set_ramp();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    check("rs_done_early", 32'(bus.done), 32'd0);
    tick();
    check("rs_done", 32'(bus.done), 32'd1);
    check("rs_t5_00", 32'(tile_el(5, 0, 0)), 32'd1040);
    check("rs_ramp_bad", 32'(bad_ramp()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
